// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: frames sof-delimited bit streams into WIDTH-bit
// words and hands them off through a valid/ready holding register with sticky overrun.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdi,
  input  logic             sdi_en,
  input  logic             sof,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  shift_r;
  logic [WIDTH-1:0]  q_r;
  logic [CW-1:0]     cnt_r;
  logic              q_valid_r;
  logic              overrun_r;

  logic [WIDTH-1:0]  first_s;
  logic [WIDTH-1:0]  next_s;
  logic              done_s;
  logic              drop_s;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  // Next shift contents, word-completion and drop detection
  always_comb begin
    first_s = shift_in({WIDTH{1'b0}}, sdi);
    next_s  = shift_in(shift_r, sdi);
    done_s  = 1'b0;
    drop_s  = 1'b0;
    if ((state_r == SHIFT) && sdi_en && !sof && (cnt_r == LAST_BIT)) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
    if (done_s && q_valid_r && !q_ready) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Framing FSM, holding register and sticky overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      shift_r   <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      q_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sdi_en && sof) begin
            shift_r <= first_s;
            cnt_r   <= CW'(1);
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          if (sdi_en) begin
            // An early sof restarts the word without touching the flags
            if (sof) begin
              shift_r <= first_s;
              cnt_r   <= CW'(1);
            end else if (cnt_r == LAST_BIT) begin
              shift_r <= next_s;
              cnt_r   <= {CW{1'b0}};
              state_r <= IDLE;
            end else begin
              shift_r <= next_s;
              cnt_r   <= cnt_r + CW'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase

      if (done_s && (!q_valid_r || q_ready)) begin
        q_r       <= next_s;
        q_valid_r <= 1'b1;
      end else if (q_valid_r && q_ready) begin
        q_valid_r <= 1'b0;
      end

      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_ovr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign overrun = overrun_r;
  assign busy    = (state_r == SHIFT);

endmodule
